bcd_countdown_ctrl: RTL and testbench
=====================================

Name: bcd_countdown_ctrl

Overview:
Controller that sequences a cascade of mod-10 (BCD) digit counters as a programmable countdown timer. Accepts a BCD preset over a valid/ready load port. Run/pause is driven by start/stop strobes, and the count decrements once per prescaled tick. Signals completion with a one-cycle done pulse. Sits between control logic (buttons/CPU strobes) and the digit display/decoder path.

Parameters:
DIGITS, 4, number of cascaded BCD digits (1..8)
PRESCALE, 1000, clk cycles per count decrement (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
load_valid  in  1  preset offered
load_ready  out  1  preset can be accepted
load_value  in  4*DIGITS  BCD preset, digit 0 in [3:0]
start  in  1  run/resume strobe
stop  in  1  pause strobe
count_value  out  4*DIGITS  current BCD count
tick  out  1  one-cycle pulse on each decrement
busy  out  1  high in RUN
done  out  1  one-cycle pulse when count reaches zero

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: state=IDLE, count_value=0, reload register=0, prescaler=0, tick=0, busy=0, done=0.
- rst has priority over all other inputs. Reset mid-run takes effect on the next edge.
- States:
  - IDLE: start with count!=0 -> RUN. Start with count==0 -> DONE.
  - RUN: stop -> PAUSE. Count reaches 0 on a tick -> DONE.
  - PAUSE: start -> RUN. The prescaler phase is held, not cleared.
  - DONE: start -> reload from the reload register; go to RUN if it is nonzero, else stay in DONE and pulse done again.
- Stop and start in the same cycle: stop wins.
- load_ready is combinational and equals (state != RUN).
- Load handshake:
  - Accepted on load_valid && load_ready.
  - On accept, count and the reload register both take load_value, prescaler clears, state -> IDLE.
  - Load has priority over start in the same cycle.
  - Any digit >9 is clamped to 9.
- Prescaler counts 0..PRESCALE-1 only in RUN. At PRESCALE-1 it wraps to 0, tick=1 (registered, same edge as the decrement), and count decrements.
- BCD decrement:
  - Digit 0 decrements.
  - A digit at 0 wraps to 9 and borrows from the next digit.
  - Count is never decremented below 0.
- When a decrement produces count==0, the state becomes DONE on that edge and done=1 for exactly that following cycle.
- busy = (state==RUN), registered with state.
- Latency: first tick occurs PRESCALE cycles after start is sampled. Full run from N takes N*PRESCALE cycles.

Optional Feature:
- Macro: BCD_COUNTDOWN_AUTO_RELOAD_EN.
- Defined: on reaching zero in RUN, count reloads from the reload register on the same edge, state stays RUN, and done pulses per wrap. If the reload value is 0, the block behaves as if the macro were undefined.
- Undefined: the block stops in DONE as described above.

Decomposition:
- Package bcd_countdown_pkg holds:
  - state enum (IDLE, RUN, PAUSE, DONE), 2 bits
  - BCD_MAX = 4'd9
  - BCD_W = 4
  - clamp function
- One sub-module, bcd_digit_down: a single mod-10 down digit. Generated DIGITS times and chained via borrow.
  - Inputs: clk, rst, load, load_val, dec_en, borrow_in.
  - Outputs: digit, borrow_out (asserted when digit==0 and decrementing).

Test Plan:
All scenarios use DIGITS=2, PRESCALE=3.
- Load 0x12, start -> count 0x11 after 3 cycles, then 0x10, 0x09, ... 0x00 at cycle 36; done high one cycle; busy low after.
- Load 0x10, start -> first tick gives 0x09 (borrow/wrap); tick pulses every 3rd cycle exactly.
- Run from 0x09, stop when count=0x07 and prescaler=1 -> count holds 10 cycles, no tick. start -> next tick after 2 cycles (phase preserved). Simultaneous start+stop keeps PAUSE.
- Load 0x3C -> count_value=0x39. Load 0x00 then start -> DONE, done one pulse, zero ticks. load_valid during RUN -> load_ready=0, value ignored.
- rst asserted at count 0x05 in RUN -> next cycle count=0x00, IDLE, busy=0, load_ready=1.
- With BCD_COUNTDOWN_AUTO_RELOAD_EN, load 0x02, start -> 0x01, then 0x02 (reload) with done pulse, repeating; busy stays 1.

Source files
------------

// File: rtl/bcd_countdown_pkg.sv
// Shared types and helpers for the BCD countdown controller.
package bcd_countdown_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_countdown_ctrl_digit.sv
// Single mod-10 down-counting digit; borrows to the next digit when wrapping 0 -> 9.
module bcd_digit_down
  import bcd_countdown_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             dec_en,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out
);

  logic [BCD_W-1:0] digit_q;

  assign digit      = digit_q;
  assign borrow_out = dec_en && borrow_in && (digit_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= '0;
    end else if (load) begin
      digit_q <= load_val;
    end else if (dec_en && borrow_in) begin
      digit_q <= (digit_q == '0) ? BCD_MAX : digit_q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_countdown_ctrl.sv
// Programmable BCD countdown timer: valid/ready preset load, start/stop control, prescaled ticks.
// Build with BCD_COUNTDOWN_AUTO_RELOAD_EN to reload and keep running on each wrap to zero.
module bcd_countdown_ctrl
  import bcd_countdown_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [BCD_W*DIGITS-1:0] load_value,
  input  logic                    start,
  input  logic                    stop,
  output logic [BCD_W*DIGITS-1:0] count_value,
  output logic                    tick,
  output logic                    busy,
  output logic                    done
);

  localparam int CW = BCD_W * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [CW-1:0]   reload_q, reload_d;
  logic            tick_q, tick_d;
  logic            busy_q;
  logic            done_q, done_d;

  logic [CW-1:0]   load_clamped;
  logic            cnt_load;
  logic [CW-1:0]   cnt_load_val;
  logic            dec_en;
  logic [DIGITS:0] borrow;
  logic            underflow;
  logic            count_zero;
  logic            count_one;
  logic            run_start;

  assign load_ready = (state_q != RUN);
  assign tick       = tick_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign count_zero = (count_value == '0);
  assign count_one  = (count_value == CW'(1));
  assign run_start  = start && !stop;

  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_clamped[i*BCD_W +: BCD_W] = bcd_clamp(load_value[i*BCD_W +: BCD_W]);
    end
  end

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    reload_d     = reload_q;
    tick_d       = 1'b0;
    done_d       = 1'b0;
    dec_en       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = reload_q;

    if (load_valid && load_ready) begin
      cnt_load     = 1'b1;
      cnt_load_val = load_clamped;
      reload_d     = load_clamped;
      presc_d      = '0;
      state_d      = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (run_start) begin
            if (count_zero) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          // Pausing freezes the prescaler on this edge so resume keeps the phase.
          if (stop) begin
            state_d = PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
            dec_en  = 1'b1;
            if (count_one) begin
              done_d = 1'b1;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
              if (reload_q != '0) begin
                cnt_load = 1'b1;
              end else begin
                state_d = DONE;
              end
`else
              state_d = DONE;
`endif
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        PAUSE: begin
          if (run_start) state_d = RUN;
        end
        DONE: begin
          if (run_start) begin
            cnt_load = 1'b1;
            presc_d  = '0;
            if (reload_q == '0) done_d = 1'b1;
            else                state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A borrow out of the top digit would mean decrementing past zero; force zero instead.
  assign borrow[0] = 1'b1;
  assign underflow = borrow[DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_down u_digit (
      .clk        (clk),
      .rst        (rst),
      .load       (cnt_load || underflow),
      .load_val   (underflow ? '0 : cnt_load_val[g*BCD_W +: BCD_W]),
      .dec_en     (dec_en),
      .borrow_in  (borrow[g]),
      .digit      (count_value[g*BCD_W +: BCD_W]),
      .borrow_out (borrow[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      reload_q <= '0;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      reload_q <= reload_d;
      tick_q   <= tick_d;
      busy_q   <= (state_d == RUN);
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_bcd_countdown_ctrl.sv
// Directed-vector bench for bcd_countdown_ctrl with DIGITS=2, PRESCALE=3.
module tb_bcd_countdown_ctrl;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_value;
  logic       start;
  logic       stop;
  logic [7:0] count_value;
  logic       tick;
  logic       busy;
  logic       done;

  int vec_cnt = 0;
  int err_cnt = 0;

  bcd_countdown_ctrl #(.DIGITS(2), .PRESCALE(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_value  (load_value),
    .start       (start),
    .stop        (stop),
    .count_value (count_value),
    .tick        (tick),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load_valid = 1'b1;
    load_value = v;
    step();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int ticks;
  int dones;

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_value = '0; start = 1'b0; stop = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_count", 32'(count_value), 32'h00);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(load_ready), 1);

    // Full countdown from 12: 36 cycles, one done pulse.
    do_load(8'h12);
    chk("ld12_count", 32'(count_value), 32'h12);
    pulse_start();
    chk("run_busy", 32'(busy), 1);
    chk("run_ready", 32'(load_ready), 0);
    step(); step();
    chk("pre_tick", 32'(tick), 0);
    step();
    chk("first_tick", 32'(tick), 1);
    chk("first_dec", 32'(count_value), 32'h11);
    ticks = 0; dones = 0;
    for (int i = 0; i < 33; i++) begin
      step();
      if (tick) ticks++;
      if (done) dones++;
    end
    chk("full_ticks", 32'(ticks), 11);
    chk("full_count", 32'(count_value), 32'h00);
    chk("full_done", 32'(done), 1);
    chk("full_dones", 32'(dones), 1);
    chk("full_busy", 32'(busy), 0);
    step();
    chk("done_pulse_end", 32'(done), 0);

    // Borrow across digits and tick spacing.
    do_load(8'h10);
    pulse_start();
    step();
    chk("t10_c1", 32'(tick), 0);
    step();
    chk("t10_c2", 32'(tick), 0);
    step();
    chk("t10_tick", 32'(tick), 1);
    chk("t10_borrow", 32'(count_value), 32'h09);
    step(); step();
    chk("t10_gap", 32'(tick), 0);
    step();
    chk("t10_tick2", 32'(tick), 1);
    chk("t10_08", 32'(count_value), 32'h08);

    // Pause with prescaler at 1, hold, resume keeps phase.
    step(); step(); step();
    chk("to_07", 32'(count_value), 32'h07);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("pause_busy", 32'(busy), 0);
    chk("pause_ready", 32'(load_ready), 1);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tick) ticks++;
    end
    chk("pause_ticks", 32'(ticks), 0);
    chk("pause_hold", 32'(count_value), 32'h07);
    start = 1'b1; stop = 1'b1;
    step();
    stop = 1'b0;
    chk("start_stop_busy", 32'(busy), 0);
    step();
    start = 1'b0;
    chk("resume_busy", 32'(busy), 1);
    step();
    chk("resume_c1", 32'(tick), 0);
    step();
    chk("resume_tick", 32'(tick), 1);
    chk("resume_06", 32'(count_value), 32'h06);

    // Load offered while running is refused.
    load_valid = 1'b1; load_value = 8'h33;
    chk("run_ld_ready", 32'(load_ready), 0);
    step();
    load_valid = 1'b0;
    chk("run_ld_ignored", 32'(count_value), 32'h06);
    chk("run_ld_busy", 32'(busy), 1);

    // Clamping and zero preset.
    stop = 1'b1; step(); stop = 1'b0;
    do_load(8'h3C);
    chk("clamp_3c", 32'(count_value), 32'h39);
    do_load(8'hF3);
    chk("clamp_f3", 32'(count_value), 32'h93);
    do_load(8'h00);
    pulse_start();
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_tick", 32'(tick), 0);
    ticks = 0; dones = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (tick) ticks++;
      if (done) dones++;
    end
    chk("zero_no_ticks", 32'(ticks), 0);
    chk("zero_no_redone", 32'(dones), 0);
    pulse_start();
    chk("zero_restart_done", 32'(done), 1);

    // Reset in the middle of a run.
    do_load(8'h05);
    pulse_start();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_count", 32'(count_value), 32'h00);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_ready", 32'(load_ready), 1);
    chk("mrst_tick", 32'(tick), 0);

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    do_load(8'h02);
    pulse_start();
    step(); step(); step();
    chk("ar_01", 32'(count_value), 32'h01);
    step(); step(); step();
    chk("ar_reload", 32'(count_value), 32'h02);
    chk("ar_done", 32'(done), 1);
    chk("ar_busy", 32'(busy), 1);
    step(); step(); step();
    chk("ar_01b", 32'(count_value), 32'h01);
    chk("ar_done_low", 32'(done), 0);
    chk("ar_busy2", 32'(busy), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
